// File: rtl/instr_fetch_sequencer.sv
// Program-counter sequencer: feeds the instruction memory address port and presents fetched words
// to decode over valid/ready. Optional address bounds check enabled by IFC_BOUNDS_CHECK_EN.
module instr_fetch_sequencer #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned PROG0_BASE = 0,
    parameter int unsigned PROG1_BASE = 15,
    parameter int unsigned LAST_ADDR  = 80,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              prog_sel,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt,
    output logic              busy,
    output logic              fault,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StHalt  = 2'd2;
    localparam logic [1:0] StFault = 2'd3;

    localparam logic [ADDR_W-1:0] Prog0Base = ADDR_W'(PROG0_BASE);
    localparam logic [ADDR_W-1:0] Prog1Base = ADDR_W'(PROG1_BASE);

    if ((LAST_ADDR >> ADDR_W) != 0) begin : gen_last_addr_check
        $error("LAST_ADDR lies outside the instruction address space");
    end

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [ADDR_W-1:0] next_pc;
    logic              running;
    logic              accept;
    logic              out_of_range;

    assign running     = (state_q == StRun);
    assign instr_valid = running & ~redirect & ~halt;
    assign accept      = instr_valid & instr_ready;
    assign instr       = imem_data;
    assign instr_pc    = fetch_pc_q;
    assign busy        = running;
    assign retired     = retired_q;

    // Redirect wins over sequential advance; a stall re-reads the same word so instr holds.
    always_comb begin
        next_pc = fetch_pc_q;
        if (redirect) begin
            next_pc = redirect_target;
        end else if (accept) begin
            next_pc = fetch_pc_q + ADDR_W'(1);
        end
    end

`ifdef IFC_BOUNDS_CHECK_EN
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LAST_ADDR);

    logic fault_q, fault_d;

    assign out_of_range = running & (next_pc > LastAddr);
    assign fault        = fault_q;
`else
    assign out_of_range = 1'b0;
    assign fault        = 1'b0;
`endif

    // Out-of-range addresses are never issued: fetch_pc keeps its last legal value.
    always_comb begin
        if (!running) begin
            if (start) begin
                imem_addr = prog_sel ? Prog1Base : Prog0Base;
            end else begin
                imem_addr = fetch_pc_q;
            end
        end else if (out_of_range) begin
            imem_addr = fetch_pc_q;
        end else begin
            imem_addr = next_pc;
        end
    end

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
`ifdef IFC_BOUNDS_CHECK_EN
        fault_d   = fault_q;
`endif
        case (state_q)
            StRun: begin
                if (halt) begin
                    state_d = StHalt;
                end else if (out_of_range) begin
                    state_d = StFault;
`ifdef IFC_BOUNDS_CHECK_EN
                    fault_d = 1'b1;
`endif
                end
                if (accept && (retired_q != {CNT_W{1'b1}})) begin
                    retired_d = retired_q + CNT_W'(1);
                end
            end
            default: begin
                if (start) begin
                    state_d   = StRun;
                    retired_d = '0;
`ifdef IFC_BOUNDS_CHECK_EN
                    fault_d   = 1'b0;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            fetch_pc_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= imem_addr;
            retired_q  <= retired_d;
        end
    end

`ifdef IFC_BOUNDS_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Randomised and directed bench for instr_fetch_sequencer against a cycle-level behavioural model;
// follows IFC_BOUNDS_CHECK_EN to match the build under test.
module tb_instr_fetch_sequencer;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int CW   = 16;
    localparam int LAST = 80;

    localparam int MIdle  = 0;
    localparam int MRun   = 1;
    localparam int MHalt  = 2;
    localparam int MFault = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          start, prog_sel, instr_ready, redirect, halt;
    logic [AW-1:0] redirect_target;
    logic [AW-1:0] imem_addr, instr_pc;
    logic [DW-1:0] imem_data, instr;
    logic          instr_valid, busy, fault;
    logic [CW-1:0] retired;

    instr_fetch_sequencer dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .prog_sel        (prog_sel),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt),
        .busy            (busy),
        .fault           (fault),
        .retired         (retired)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] mem [1024];
    always @(posedge clock) imem_data <= mem[imem_addr];

    // Model: what decode sees (mode, presented pc, retired count, fault flag).
    int m_mode, m_pc, m_ret;
    bit m_fault;
    int n_mode, n_pc, n_ret;
    bit n_fault;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_mode = MIdle; m_pc = 0; m_ret = 0; m_fault = 0;
    endtask

    // Drive inputs at the falling edge, check all outputs, and work out the model's next cycle.
    task automatic drive(input bit st, input bit sel, input bit rdy, input bit rd,
                         input int tgt, input bit hl);
        bit valid, acc, oob;
        int want, addr;
        @(negedge clock);
        start = st; prog_sel = sel; instr_ready = rdy; redirect = rd;
        redirect_target = AW'(tgt); halt = hl;
        #1;
        valid = (m_mode == MRun) && !rd && !hl;
        acc   = valid && rdy;
        oob   = 0;
        n_mode = m_mode; n_ret = m_ret; n_fault = m_fault;
        if (m_mode != MRun) begin
            addr = st ? (sel ? 15 : 0) : m_pc;
            if (st) begin
                n_mode = MRun; n_ret = 0; n_fault = 0;
            end
        end else begin
            want = rd ? tgt : (acc ? (m_pc + 1) % 1024 : m_pc);
`ifdef IFC_BOUNDS_CHECK_EN
            oob = (want > LAST);
`endif
            addr = oob ? m_pc : want;
            if (hl) n_mode = MHalt;
            else if (oob) begin
                n_mode = MFault; n_fault = 1;
            end
            if (acc && m_ret < 65535) n_ret = m_ret + 1;
        end
        n_pc = addr;
        chk("imem_addr", imem_addr, addr);
        chk("instr_valid", instr_valid, valid);
        chk("busy", busy, m_mode == MRun);
        chk("instr_pc", instr_pc, m_pc);
        chk("retired", retired, m_ret);
        chk("fault", fault, m_fault);
        if (valid) chk("instr", instr, mem[m_pc]);
    endtask

    task automatic adv();
        @(posedge clock);
        m_mode = n_mode; m_pc = n_pc; m_ret = n_ret; m_fault = n_fault;
    endtask

    task automatic step(input bit st, input bit sel, input bit rdy, input bit rd,
                        input int tgt, input bit hl);
        drive(st, sel, rdy, rd, tgt, hl);
        adv();
    endtask

    task automatic do_reset();
        @(negedge clock);
        start = 0; prog_sel = 0; instr_ready = 0; redirect = 0; redirect_target = '0; halt = 0;
        reset_n = 0;
        #1;
        chk("reset instr_valid", instr_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset retired", retired, 0);
        chk("reset fault", fault, 0);
        chk("reset instr_pc", instr_pc, 0);
        model_reset();
        @(negedge clock);
        reset_n = 1;
    endtask

    logic [DW-1:0] held;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[15] = 32'hA81E0000;
        reset_n = 1;
        do_reset();

        // Fibonacci entry, one accept per cycle, then a taken branch back to 6.
        step(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 1, 0, 0, 0);
            chk("seq pc", instr_pc, i);
            chk("seq retired", retired, i);
            adv();
        end
        drive(0, 0, 1, 1, 6, 0);
        chk("squash pc", instr_pc, 9);
        chk("squash valid", instr_valid, 0);
        chk("redirect addr", imem_addr, 6);
        adv();
        drive(0, 0, 1, 0, 0, 0);
        chk("target pc", instr_pc, 6);
        chk("target valid", instr_valid, 1);
        chk("squash not retired", retired, 9);
        adv();
        step(0, 0, 1, 0, 0, 1);

        // Factorial entry, stall at 17, halt at 22, restart.
        drive(1, 1, 1, 0, 0, 0);
        chk("halted busy", busy, 0);
        adv();
        drive(0, 0, 1, 0, 0, 0);
        chk("prog1 pc", instr_pc, 15);
        chk("prog1 instr", instr, 32'hA81E0000);
        chk("prog1 busy", busy, 1);
        adv();
        step(0, 0, 1, 0, 0, 0);
        held = instr;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            if (i == 0) held = instr;
            chk("stall pc", instr_pc, 17);
            chk("stall addr", imem_addr, 17);
            chk("stall instr", instr, held);
            chk("stall retired", retired, 2);
            adv();
        end
        step(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        chk("release pc", instr_pc, 18);
        adv();
        for (int i = 0; i < 50 && m_pc != 22; i++) step(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 1);
        chk("halt pc", instr_pc, 22);
        chk("halt valid", instr_valid, 0);
        adv();
        drive(0, 0, 1, 0, 0, 0);
        chk("after halt busy", busy, 0);
        chk("after halt valid", instr_valid, 0);
        adv();
        step(1, 0, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0, 0);
        chk("restart pc", instr_pc, 0);
        chk("restart retired", retired, 0);
        adv();
        drive(0, 0, 1, 0, 0, 0);
        chk("start in run ignored", instr_pc, 1);
        adv();

        // Asynchronous reset mid-fetch.
        do_reset();
        step(1, 0, 1, 0, 0, 0);
`ifdef IFC_BOUNDS_CHECK_EN
        drive(0, 0, 1, 1, 90, 0);
        chk("oob addr held", imem_addr, 0);
        adv();
        drive(0, 0, 1, 0, 0, 0);
        chk("fault set", fault, 1);
        chk("fault valid", instr_valid, 0);
        chk("fault busy", busy, 0);
        adv();
        step(1, 1, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        chk("fault cleared", fault, 0);
        chk("fault restart pc", instr_pc, 15);
        adv();
`else
        step(0, 0, 1, 1, 1023, 0);
        drive(0, 0, 1, 0, 0, 0);
        chk("wrap pc", instr_pc, 1023);
        chk("wrap addr", imem_addr, 0);
        adv();
        drive(0, 0, 1, 0, 0, 0);
        chk("wrapped pc", instr_pc, 0);
        adv();
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int tgt;
`ifdef IFC_BOUNDS_CHECK_EN
            tgt = ($urandom % 8 == 0) ? $urandom_range(1023, 81) : $urandom_range(80, 0);
`else
            tgt = $urandom % 1024;
`endif
            step($urandom % 20 == 0, $urandom % 2 == 1, $urandom % 10 < 7,
                 $urandom % 10 == 0, tgt, $urandom % 40 == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
Program-counter sequencer that drives the 10-bit instruction-memory address port and hands fetched 32-bit instructions to decode over a valid/ready handshake. It selects the program entry point (fibonacci at word 0, factorial at word 15), and follows branch/jump redirects from execute. It stops on halt from decode. It sits between the instruction memory (1-cycle registered read) and the decode stage.

Parameters:
ADDR_W, 10, instruction address width (matches memory address port)
DATA_W, 32, instruction width
PROG0_BASE, 0, entry word for prog_sel=0 (fibonacci)
PROG1_BASE, 15, entry word for prog_sel=1 (factorial)
LAST_ADDR, 80, highest populated memory word (used only by optional feature)
CNT_W, 16, width of retired-instruction counter

Ports:
clock  in  1  single clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  pulse: begin fetching selected program (honoured in IDLE/HALT/FAULT)
prog_sel  in  1  program select, sampled with start
imem_addr  out  ADDR_W  address to instruction memory (combinational from state, see below)
imem_data  in  DATA_W  memory read data; corresponds to address sampled on previous edge
instr  out  DATA_W  instruction to decode (= imem_data)
instr_pc  out  ADDR_W  word address of instr
instr_valid  out  1  instr is valid and on-path
instr_ready  in  1  decode accepts instr this cycle
redirect  in  1  execute: branch/jump taken, squash presented instr
redirect_target  in  ADDR_W  new fetch word address
halt  in  1  decode: program end, stop fetching
busy  out  1  state==RUN
fault  out  1  out-of-range fetch (optional feature; constant 0 otherwise)
retired  out  CNT_W  accepted-instruction count since last start

Behaviour:
- States: IDLE, RUN, HALT, FAULT. Reset (reset_n=0, async): state=IDLE, fetch_pc=0, retired=0, fault=0; instr_valid=0, busy=0.
- fetch_pc register: updated every edge to the value of imem_addr; therefore imem_data always belongs to fetch_pc; instr_pc=fetch_pc.
- accept = instr_valid & instr_ready.
- instr_valid = (state==RUN) & ~redirect & ~halt.
- imem_addr, IDLE/HALT/FAULT: start ? (prog_sel ? PROG1_BASE : PROG0_BASE) : fetch_pc.
- imem_addr, RUN, priority order: redirect -> redirect_target; accept -> fetch_pc+1 (mod 2^ADDR_W); else fetch_pc (stall: memory re-reads same word, instr held stable).
- Transitions: IDLE/HALT/FAULT --start--> RUN (retired<=0, fault<=0). RUN --halt--> HALT (halt has priority over redirect and accept; presented instr not accepted). RUN otherwise stays.
- Latency: start at edge k -> instr_valid high in cycle after edge k, instr=RAM[base]. Redirect in cycle c -> presented instr squashed in c, target instr valid in c+1 (one-bubble penalty). Back-to-back accepts give 1 instr/cycle.
- redirect and accept same cycle impossible by construction (valid masked); redirect while instr_ready=1 still squashes.
- retired increments on accept, saturates at 2^CNT_W-1.
- start while RUN ignored. reset_n low mid-fetch: immediate return to IDLE, outputs to reset values.

Optional Feature:
IFC_BOUNDS_CHECK_EN: when defined, any imem_addr value in RUN exceeding LAST_ADDR (sequential increment or redirect_target) is not issued; instead on that edge state<=FAULT, fault<=1, fetch_pc holds last legal value, instr_valid=0 until start. When not defined, addresses wrap modulo 2^ADDR_W, FAULT state unreachable, fault tied 0.

Test Plan:
- Reset then start, prog_sel=0, instr_ready=1 -> instr_pc 0,1,2,... one per cycle, instr=memory words 0..; retired counts 1,2,3.
- start, prog_sel=1 -> first valid instr_pc=15, instr=0xA81E0000; busy=1.
- instr_ready=0 for 3 cycles at pc=17 -> instr_pc=17 and instr stable all 3 cycles, imem_addr=17, retired unchanged; release -> pc 18 next cycle.
- At pc=9 assert redirect, target=6 -> instr_valid=0 that cycle, next cycle instr_pc=6 valid; retired not incremented for squashed word.
- halt at pc=22 -> state HALT next edge, instr_valid=0, busy=0; start prog_sel=0 -> instr_pc=0, retired=0.
- With IFC_BOUNDS_CHECK_EN: redirect target=90 -> fault=1, instr_valid=0, FAULT; start clears fault. Without: sequential fetch from 1023 -> 0.
